// File: rtl/param_serial_pkg.sv
// Shared constants and FSM state type for the nibble serializer and its
// companion deserializing register.
package param_serial_pkg;

    localparam int SUB_W = 4;
    localparam int NSUB  = 8;
    localparam int IDX_W = $clog2(NSUB);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

endpackage

// File: rtl/param_serializer_stage.sv
// One-entry staging register with valid/ready on both sides. It holds the
// next word while the current one is still shifting out. Push and pop never
// coincide: a push needs the entry empty and a pop needs it full.
module param_serializer_stage #(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_val,
    output logic              in_rdy,
    input  logic [WORD_W-1:0] in_data,
    output logic              out_val,
    input  logic              out_rdy,
    output logic [WORD_W-1:0] out_data
);

    logic              full_q, full_d;
    logic [WORD_W-1:0] data_q, data_d;

    // Next-state for the single entry: fill on push, empty on pop.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (in_val && in_rdy) begin
            full_d = 1'b1;
            data_d = in_data;
        end else if (out_val && out_rdy) begin
            full_d = 1'b0;
        end
    end

    // Entry state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign in_rdy   = !full_q;
    assign out_val  = full_q;
    assign out_data = data_q;

endmodule

// File: rtl/param_nibble_serializer.sv
// Splits a WORD_W-bit word into SUB_W-bit subwords and emits them
// LSB-subword first over a valid/ready link, with the subword index and a
// last flag alongside.
//
// Build option NIBBLE_SERIALIZER_PRELOAD_EN adds a one-entry staging register
// so the next word can be accepted while the current one shifts out, giving
// back-to-back output with no bubble. Without it, a new word is accepted only
// in IDLE (8 subwords per 9 cycles sustained).
module param_nibble_serializer
    import param_serial_pkg::state_e;
    import param_serial_pkg::ST_IDLE;
    import param_serial_pkg::ST_SHIFT;
#(
    parameter int  WORD_W = param_serial_pkg::SUB_W * param_serial_pkg::NSUB,
    parameter int  SUB_W  = param_serial_pkg::SUB_W,
    localparam int NSUB   = WORD_W / SUB_W,
    localparam int IDX_W  = $clog2(NSUB)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_val,
    output logic              load_rdy,
    input  logic [WORD_W-1:0] load_data,
    output logic              sub_val,
    input  logic              sub_rdy,
    output logic [SUB_W-1:0]  sub_data,
    output logic [IDX_W-1:0]  sub_idx,
    output logic              sub_last,
    output logic              busy
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSUB - 1);

    state_e            state_q, state_d;
    logic [WORD_W-1:0] sr_q, sr_d;
    logic [IDX_W-1:0]  idx_q, idx_d;

    logic              load_fire;
    logic              sub_fire;
    logic              last_fire;
    logic              stage_full;
    logic              reload_val;
    logic [WORD_W-1:0] reload_data;

    // Outputs decode straight from registers, so load_rdy and sub_val never
    // depend combinationally on sub_rdy or load_val.
    assign sub_val   = (state_q == ST_SHIFT);
    assign sub_data  = sub_val ? sr_q[SUB_W-1:0] : '0;
    assign sub_idx   = idx_q;
    assign sub_last  = sub_val && (idx_q == LAST_IDX);
    assign busy      = sub_val || stage_full;

    assign load_fire = load_val && load_rdy;
    assign sub_fire  = sub_val && sub_rdy;
    assign last_fire = sub_fire && (idx_q == LAST_IDX);

`ifdef NIBBLE_SERIALIZER_PRELOAD_EN
    logic              stage_push;
    logic              stage_in_rdy;
    logic [WORD_W-1:0] stage_data;

    // A word is staged only when the shift register is busy and not freeing
    // up on this edge; otherwise it goes straight into the shift register.
    assign stage_push = load_fire && (state_q == ST_SHIFT) && !last_fire;

    param_serializer_stage #(
        .WORD_W (WORD_W)
    ) u_stage (
        .clk      (clk),
        .reset    (reset),
        .in_val   (stage_push),
        .in_rdy   (stage_in_rdy),
        .in_data  (load_data),
        .out_val  (stage_full),
        .out_rdy  (last_fire),
        .out_data (stage_data)
    );

    assign load_rdy    = stage_in_rdy;
    // On the last subword, a staged word wins; a same-cycle load is only
    // possible when the stage is empty.
    assign reload_val  = stage_full || load_fire;
    assign reload_data = stage_full ? stage_data : load_data;
`else
    assign load_rdy    = (state_q == ST_IDLE);
    assign stage_full  = 1'b0;
    assign reload_val  = 1'b0;
    assign reload_data = '0;
`endif

    // FSM, shift register and index next-state.
    // NOTE: every variable gets a default at the top of the block so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (load_fire) begin
                    state_d = ST_SHIFT;
                    sr_d    = load_data;
                    idx_d   = '0;
                end
            end
            ST_SHIFT: begin
                if (sub_fire) begin
                    if (idx_q != LAST_IDX) begin
                        sr_d  = sr_q >> SUB_W;
                        idx_d = idx_q + 1'b1;
                    end else if (reload_val) begin
                        sr_d  = reload_data;
                        idx_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                        sr_d    = '0;
                        idx_d   = '0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, shift register and index registers.
    // NOTE: non-blocking assignments here so every flop samples the values
    // from before the edge, independent of statement order. The shift
    // register is reset too, so sub_data reads zero straight out of reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            sr_q    <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: tb/tb_param_nibble_serializer.sv
// Self-checking bench for param_nibble_serializer. Expected subwords are
// queued when a load fires and compared (data, index, last) while the DUT
// presents them; a deserializer model reassembles each word for loopback.
// Compile with NIBBLE_SERIALIZER_PRELOAD_EN to check the staged build.
module tb_param_nibble_serializer;

    localparam int NSUB = 8;

`ifdef NIBBLE_SERIALIZER_PRELOAD_EN
    localparam int B2B_SPAN = 15;
`else
    localparam int B2B_SPAN = 16;
`endif

    typedef struct {
        logic [3:0] data;
        logic [2:0] idx;
        logic       last;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        load_val;
    logic        load_rdy;
    logic [31:0] load_data;
    logic        sub_val;
    logic        sub_rdy;
    logic [3:0]  sub_data;
    logic [2:0]  sub_idx;
    logic        sub_last;
    logic        busy;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          rdy_mode = 0;
    int          fire_first = -1;
    int          fire_last = -1;
    int          loop_cnt = 0;

    exp_t        exp_q[$];
    logic [31:0] src_q[$];
    logic [3:0]  deser [NSUB];

    param_nibble_serializer dut (
        .clk       (clk),
        .reset     (reset),
        .load_val  (load_val),
        .load_rdy  (load_rdy),
        .load_data (load_data),
        .sub_val   (sub_val),
        .sub_rdy   (sub_rdy),
        .sub_data  (sub_data),
        .sub_idx   (sub_idx),
        .sub_last  (sub_last),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Consumer ready: 0 = always ready, 1 = repeating 1,0,0,1, else random.
    initial begin
        logic [3:0] pat;
        int         pi;
        pat = 4'b1001;
        pi  = 0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       sub_rdy = 1'b1;
                1: begin
                    sub_rdy = pat[pi];
                    pi      = (pi + 1) % 4;
                end
                default: sub_rdy = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Scoreboard monitor, sampling on the falling edge.
    initial forever begin
        @(negedge clk);
        if (!reset) begin
            exp_q.delete();
            src_q.delete();
        end else begin
            check("busy", 32'(busy), 32'(exp_q.size() != 0));
            check("sub_val", 32'(sub_val), 32'(exp_q.size() != 0));
`ifdef NIBBLE_SERIALIZER_PRELOAD_EN
            check("load_rdy", 32'(load_rdy), 32'(exp_q.size() <= NSUB));
`else
            check("load_rdy", 32'(load_rdy), 32'(exp_q.size() == 0));
`endif
            if (!sub_val) begin
                check("idle_out", {24'd0, sub_last, sub_idx, sub_data}, 32'd0);
            end else if (exp_q.size() != 0) begin
                check("sub_data", 32'(sub_data), 32'(exp_q[0].data));
                check("sub_idx", 32'(sub_idx), 32'(exp_q[0].idx));
                check("sub_last", 32'(sub_last), 32'(exp_q[0].last));
                if (sub_rdy) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (fire_first < 0) fire_first = cyc;
                    fire_last = cyc;
                    deser[sub_idx] = sub_data;
                    if (e.last) begin
                        logic [31:0] dw;
                        for (int i = 0; i < NSUB; i++) dw[i*4 +: 4] = deser[i];
                        if (src_q.size() != 0) check("loopback", dw, src_q.pop_front());
                        loop_cnt++;
                    end
                end
            end
            if (load_val && load_rdy) begin
                for (int i = 0; i < NSUB; i++) begin
                    exp_t e;
                    e.data = load_data[i*4 +: 4];
                    e.idx  = 3'(i);
                    e.last = (i == NSUB - 1);
                    exp_q.push_back(e);
                end
                src_q.push_back(load_data);
            end
        end
    end

    // Offer one word and hold it until accepted; returns 1 ns after the accepting edge.
    task automatic send_word(input logic [31:0] w);
        int n;
        n         = 0;
        load_val  = 1'b1;
        load_data = w;
        do begin
            @(negedge clk);
            n++;
        end while (!load_rdy && n < 400);
        if (!load_rdy) check("load_timeout", 32'(load_rdy), 32'd1);
        @(posedge clk);
        #1;
        load_val  = 1'b0;
        load_data = '0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || exp_q.size() != 0) && n < 2000);
        if (busy || exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timed out");
    end

    initial begin
        int n;
        reset     = 1'b1;
        load_val  = 1'b0;
        load_data = '0;
        sub_rdy   = 1'b1;
        #1 reset  = 1'b0;
        #2;
        check("rst_sub_val", 32'(sub_val), 32'd0);
        check("rst_sub_data", 32'(sub_data), 32'd0);
        check("rst_sub_idx", 32'(sub_idx), 32'd0);
        check("rst_sub_last", 32'(sub_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_load_rdy", 32'(load_rdy), 32'd1);
        #19 reset = 1'b1;
        #1;
        check("rel_load_rdy", 32'(load_rdy), 32'd1);
        @(posedge clk);
        #1;

        // Single word: nibbles 1..8 on consecutive cycles.
        rdy_mode   = 0;
        fire_first = -1;
        send_word(32'h8765_4321);
        wait_idle();
        check("single_span", 32'(fire_last - fire_first), 32'd7);

        // Backpressure with 1,0,0,1 ready pattern.
        rdy_mode = 1;
        send_word(32'hDEAD_BEEF);
        wait_idle();
        rdy_mode = 0;

        // Back-to-back words.
        @(posedge clk);
        #1;
        fire_first = -1;
        send_word(32'h0000_0001);
        send_word(32'hF000_0000);
        wait_idle();
        check("b2b_span", 32'(fire_last - fire_first), 32'(B2B_SPAN));

        // Reset mid-word at sub_idx 3.
        send_word(32'h1357_9BDF);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(sub_val && sub_idx == 3'd3) && n < 50);
        check("mid_reached_idx3", 32'(sub_idx), 32'd3);
        reset = 1'b0;
        #1;
        check("mid_rst_sub_val", 32'(sub_val), 32'd0);
        check("mid_rst_sub_idx", 32'(sub_idx), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rel_load_rdy", 32'(load_rdy), 32'd1);
        @(posedge clk);
        #1;
        fire_first = -1;
        send_word(32'hCAFE_F00D);
        wait_idle();
        check("after_rst_span", 32'(fire_last - fire_first), 32'd7);

        // Loopback over random words with random backpressure.
        loop_cnt = 0;
        rdy_mode = 2;
        repeat (100) send_word($urandom);
        wait_idle();
        rdy_mode = 0;
        check("loopback_words", 32'(loop_cnt), 32'd100);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/param_nibble_serializer.md
# param_nibble_serializer

Splits a 32-bit word into eight 4-bit subwords and emits them LSB-nibble first, one per accepted handshake. It is the transmit-side counterpart of the nibble deserializing register and feeds the 4-bit bit-sliced datapath, and any 4-bit link, from 32-bit sources such as the register file, the PC, or memory response data. Both sides use valid/ready handshakes. The emitted subword index lets the receiving side drive its subword enable index directly.

## Interface
- `WORD_W`, 32, input word width; must be a multiple of `SUB_W`.
- `SUB_W`, 4, subword width.
- `NSUB` (derived), `WORD_W/SUB_W` = 8, subwords per word.
- `IDX_W` (derived), `$clog2(NSUB)` = 3, subword index width.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `load_val`  in  1  `load_data` is valid.
- `load_rdy`  out  1  block can accept a word this cycle.
- `load_data`  in  `WORD_W`  word to serialize.
- `sub_val`  out  1  `sub_data` is valid.
- `sub_rdy`  in  1  consumer accepts the subword.
- `sub_data`  out  `SUB_W`  current subword.
- `sub_idx`  out  `IDX_W`  position of `sub_data` within the word; 0 is bits [3:0].
- `sub_last`  out  1  high when `sub_idx == NSUB-1` and `sub_val` is high.
- `busy`  out  1  a word is in flight or staged.

## Operation
- **States:** IDLE and SHIFT. All registers are cleared by `reset`.
- **Load fire:** a load fires when `load_val && load_rdy`.
  - `load_data` is captured into shift register `sr`.
  - `idx` is set to 0.
  - State goes to SHIFT.
- **Output in SHIFT:**
  - `sub_val=1`, `sub_data=sr[SUB_W-1:0]`, `sub_idx=idx`.
  - All outputs hold stable while `sub_rdy=0`.
- **Subword fire:** a subword fires when `sub_val && sub_rdy`.
  - `sr` shifts right by `SUB_W` with zero fill.
  - `idx` increments by 1.
- **Last subword:** when the subword at `idx==NSUB-1` fires, the block returns to IDLE, or reloads (see Configuration).
- **Index width:** `idx` is exactly `IDX_W` bits. Its increment past `NSUB-1` never occurs, because the transition out of the last subword is taken first.
- **IDLE outputs:** `sub_val=0`, `sub_data=0`, `sub_idx=0`.
- **`busy`:** equals `(state==SHIFT) || stage_full`.

## Timing
- **Reset values:**
  - `sub_val=0`, `sub_data=0`, `sub_idx=0`, `sub_last=0`, `busy=0`.
  - `load_rdy=1` while reset is asserted and immediately after release.
- **Mid-operation reset:** asserting `reset` mid-word clears the block asynchronously. `sub_val` drops in the same cycle and the partial word is discarded, with no completion.
- **Latency:** a load fire at edge N gives `sub_val=1`, `sub_idx=0` from edge N+1.
- **Word duration:** with `sub_rdy` held high, the subwords occupy cycles N+1 to N+8.
- **Backpressure:**
  - `sub_rdy=0` stalls with no state change.
  - `sub_val` never deasserts mid-word except by reset.
- **No combinational paths:** `load_rdy` and `sub_val` are driven from registers only, and are not combinationally dependent on `sub_rdy` or `load_val`.

## Configuration
- **Macro:** `NIBBLE_SERIALIZER_PRELOAD_EN`.
- **Without the macro:**
  - `load_rdy = (state==IDLE)`.
  - At least one idle cycle separates words, so sustained throughput is 8 subwords per 9 cycles.
- **With the macro:** a one-entry staging register is added, with `stage_full` and `stage_data`.
  - `load_rdy = !stage_full`, so a word may be accepted during SHIFT.
  - On the last-subword fire with `stage_full=1`: `stage_data` moves to `sr`, `idx` is set to 0, the state stays SHIFT, and `stage_full` clears. Output is back-to-back with no bubble.
  - A load fire in IDLE while the stage is empty goes straight to `sr`.
  - If the last-subword fire and a load fire coincide with the stage empty, the loaded word goes to `sr` directly with no bubble.

## Structure
- **Shared package `param_serial_pkg`:**
  - constants `SUB_W=4`, `NSUB=8`, `IDX_W=3`;
  - the state enum (`ST_IDLE`, `ST_SHIFT`).
  - The deserializer uses the same constants.
- **Sub-module `param_serializer_stage`:** the one-entry staging register with valid/ready, instantiated only under the macro.
- **Top level:** owns the FSM, the shift register and the index counter.

## Test plan
- **Single word:** load `32'h8765_4321` with `sub_rdy=1` → `sub_data` 1,2,3,…,8 with `sub_idx` 0..7 on consecutive cycles; `sub_last` only with 8; IDLE afterwards.
- **Backpressure:** toggle `sub_rdy` in the pattern 1,0,0,1 during `32'hDEAD_BEEF` → each nibble is held while stalled; sequence F,E,E,B,D,A,E,D with no drop or duplicate.
- **Back-to-back words:** words A=`32'h0000_0001`, B=`32'hF000_0000`.
  - Without the macro: 1-cycle `sub_val` gap between A and B.
  - With the macro: B staged during A; `sub_idx` goes 7→0 with no gap; `load_rdy=0` while staged.
- **Reset mid-word:** assert `reset` low at `sub_idx=3` → `sub_val=0` and `sub_idx=0` immediately; after release `load_rdy=1`; the next word starts at `sub_idx=0`.
- **Loopback:** drive `sub_idx`/`sub_data` into the deserializing register on each `sub_val && sub_rdy` over 100 random words → the deserializer output equals the source word after every `sub_last`.
